// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for sync_fifo.
package sync_fifo_pkg;

    // Minimum bits to encode values 0..n-1, never less than 1.
    function automatic int unsigned calc_width(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'(1) << w) < 64'(n)) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return depth >= 2;
    endfunction

    function automatic bit afull_ok(input int unsigned depth, input int unsigned thresh);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

    function automatic bit aempty_ok(input int unsigned depth, input int unsigned thresh);
        return thresh <= depth - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with increment and synchronous clear; works for any DEPTH.
module fifo_wrap_ptr #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PTR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [PTR_WIDTH-1:0] o_ptr
);

    logic [PTR_WIDTH-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : r_ptr + PTR_WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, thresholds, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 8,
    parameter  int unsigned DEPTH         = 8,
    parameter  int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter  int unsigned AEMPTY_THRESH = 2,
    localparam int unsigned CNT_WIDTH     = calc_width(DEPTH + 1),
    localparam int unsigned PTR_WIDTH     = calc_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be >= 2");
    end
    if (!afull_ok(DEPTH, AFULL_THRESH)) begin : g_bad_afull
        $error("sync_fifo: AFULL_THRESH must be in 1..DEPTH");
    end
    if (!aempty_ok(DEPTH, AEMPTY_THRESH)) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [PTR_WIDTH-1:0]  w_wr_ptr;
    logic [PTR_WIDTH-1:0]  w_rd_ptr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_full   = (r_count == CNT_WIDTH'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en && !w_full && !flush;
    assign w_rd_acc = rd_en && !w_empty && !flush;

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_wr_acc),
        .o_ptr (w_wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_rd_acc),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    // Flags look at raw requests against the current state, so a refused half
    // of a simultaneous read/write still marks the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = r_mem[w_rd_ptr];
    assign rd_valid = !w_empty;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[w_rd_ptr];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CNT_WIDTH'(AFULL_THRESH));
    assign almost_empty = (r_count <= CNT_WIDTH'(AEMPTY_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
